lb_vfilt_ro: RTL

- Parametrised next-generation line-buffer/offset stage for the RGB video pipe.
- Applies a 3-tap vertical [1 2 1]/4 filter across NUM_CH packed channels using two internal line memories, then adds a per-frame offset with saturation.
- Sync/DE are delay-matched to the data path.
- Sits between the timing generator/input capture and downstream pixel processing; replaces the fixed-RGB, non-filtering offset stage.

---
 rtl/lb_pkg.sv | 25 ++
 rtl/lb_line_mem.sv | 38 +++
 rtl/lb_vfilt_ro.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/lb_pkg.sv
// Shared definitions for the line-buffer vertical filter / offset stage.
// Default geometry, pixel typedefs, line-count encoding and a channel slice helper.
package lb_pkg;

    localparam int LB_DATA_W   = 8;
    localparam int LB_NUM_CH   = 3;
    localparam int LB_MAX_HACT = 1920;
    localparam int LB_HOR_W    = 12;
    localparam int LB_LAT      = 3;

    typedef logic [LB_NUM_CH*LB_DATA_W-1:0] pix_t;
    typedef logic [LB_DATA_W-1:0]           chan_t;

    // Number of complete prior lines available as filter taps.
    typedef enum logic [1:0] {
        LC_NONE = 2'd0,
        LC_ONE  = 2'd1,
        LC_TWO  = 2'd2
    } lcnt_e;

    function automatic chan_t ch_slice(input pix_t p, input int unsigned ch);
        ch_slice = p[ch*LB_DATA_W +: LB_DATA_W];
    endfunction

endpackage

// File: rtl/lb_line_mem.sv
// Simple dual-port line memory, one-cycle registered read.
// A read and write to the same address in one cycle returns the old contents.
module lb_line_mem
    import lb_pkg::*;
#(
    parameter int DEPTH = LB_MAX_HACT,
    parameter int AW    = LB_HOR_W,
    parameter int DW    = LB_NUM_CH*LB_DATA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/lb_vfilt_ro.sv
// 3-tap vertical [1 2 1]/4 filter over NUM_CH packed channels with a
// per-frame saturating offset; syncs and data share a fixed 3-cycle latency.
module lb_vfilt_ro
    import lb_pkg::*;
#(
    parameter int DATA_W   = LB_DATA_W,
    parameter int NUM_CH   = LB_NUM_CH,
    parameter int MAX_HACT = LB_MAX_HACT,
    parameter int HOR_W    = LB_HOR_W
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_bypass,
    input  logic [DATA_W-1:0]        i_offset_val,
    input  logic                     i_vsync,
    input  logic                     i_hsync,
    input  logic                     i_de,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    output logic                     o_vsync,
    output logic                     o_hsync,
    output logic                     o_de,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic                     o_ovf
);

    localparam int PIX_W = NUM_CH*DATA_W;
    localparam int CNT_W = HOR_W + 1;   // one spare bit so the count can hold MAX_HACT itself
    localparam logic [CNT_W-1:0]    COL_MAX = CNT_W'(MAX_HACT);
    localparam logic [CNT_W-1:0]    COL_INC = {{HOR_W{1'b0}}, 1'b1};
    localparam logic [DATA_W+1:0]   SUM_RND = {{DATA_W{1'b0}}, 2'b10};

    logic             vs_rise_s, de_rise_s, de_fall_s, in_rng_s;
    logic [CNT_W-1:0] col_s, col_nxt_s, col_r;
    logic [HOR_W-1:0] rd_addr_s;
    lcnt_e            lcnt_r;
    logic             byp_r, ovf_r;
    logic [DATA_W-1:0] off_r;

    logic             s1_vs_r, s1_hs_r, s1_de_r, s1_ovp_r;
    logic [PIX_W-1:0] s1_x_r;
    logic [HOR_W-1:0] s1_col_r;
    lcnt_e            s1_lcnt_r;
    logic [PIX_W-1:0] l1_q_s, l2_q_s, t1_s, t2_s, f_s;
    logic [DATA_W+1:0] sum_s;

    logic             s2_vs_r, s2_hs_r, s2_de_r;
    logic [PIX_W-1:0] s2_x_r, s2_f_r, y_s;
    logic [DATA_W:0]  add_s;

    assign o_ovf = ovf_r;

    // Edge detection against the stage-1 copies of the syncs, and column bookkeeping.
    always_comb begin
        vs_rise_s = i_vsync & ~s1_vs_r;
        de_rise_s = i_de & ~s1_de_r;
        de_fall_s = ~i_de & s1_de_r;
        col_s     = de_rise_s ? '0 : col_r;
        in_rng_s  = (col_s < COL_MAX);
        if (in_rng_s) begin
            rd_addr_s = col_s[HOR_W-1:0];
            col_nxt_s = col_s + COL_INC;
        end else begin
            rd_addr_s = '0;
            col_nxt_s = COL_MAX;
        end
    end

    // Column counter, line counter, frame-latched controls and sticky overflow.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            col_r  <= '0;
            lcnt_r <= LC_NONE;
            byp_r  <= 1'b0;
            off_r  <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (i_de) begin
                col_r <= col_nxt_s;
            end
            if (vs_rise_s) begin
                lcnt_r <= LC_NONE;
                byp_r  <= i_bypass;
                off_r  <= i_offset_val;
            end else if (de_fall_s) begin
                case (lcnt_r)
                    LC_NONE: lcnt_r <= LC_ONE;
                    LC_ONE:  lcnt_r <= LC_TWO;
                    default: lcnt_r <= LC_TWO;
                endcase
            end
            // An overflowing pixel in the frame-start cycle belongs to the new frame.
            if (i_de && !in_rng_s) begin
                ovf_r <= 1'b1;
            end else if (vs_rise_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // Stage 1: input register alongside the line-memory read.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s1_vs_r   <= 1'b0;
            s1_hs_r   <= 1'b0;
            s1_de_r   <= 1'b0;
            s1_ovp_r  <= 1'b0;
            s1_x_r    <= '0;
            s1_col_r  <= '0;
            s1_lcnt_r <= LC_NONE;
        end else begin
            s1_vs_r   <= i_vsync;
            s1_hs_r   <= i_hsync;
            s1_de_r   <= i_de;
            s1_ovp_r  <= i_de & ~in_rng_s;
            s1_x_r    <= i_data;
            s1_col_r  <= rd_addr_s;
            s1_lcnt_r <= lcnt_r;
        end
    end

    // Writes trail the read by a cycle so L2 can take the value just read from L1.
    lb_line_mem #(.DEPTH(MAX_HACT), .AW(HOR_W), .DW(PIX_W)) u_l1 (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .wr_en   (s1_de_r & ~s1_ovp_r),
        .wr_addr (s1_col_r),
        .wr_data (s1_x_r),
        .rd_en   (i_de & in_rng_s),
        .rd_addr (rd_addr_s),
        .rd_data (l1_q_s)
    );

    lb_line_mem #(.DEPTH(MAX_HACT), .AW(HOR_W), .DW(PIX_W)) u_l2 (
        .clk     (i_clk),
        .rst_n   (i_rstn),
        .wr_en   (s1_de_r & ~s1_ovp_r),
        .wr_addr (s1_col_r),
        .wr_data (l1_q_s),
        .rd_en   (i_de & in_rng_s),
        .rd_addr (rd_addr_s),
        .rd_data (l2_q_s)
    );

    // Stage 2: tap selection with edge replication, then the [1 2 1] sum.
    always_comb begin
        t1_s  = s1_x_r;
        t2_s  = s1_x_r;
        f_s   = '0;
        sum_s = '0;
        if (s1_ovp_r) begin
            t1_s = s1_x_r;
            t2_s = s1_x_r;
        end else begin
            case (s1_lcnt_r)
                LC_ONE: begin
                    t1_s = l1_q_s;
                    t2_s = l1_q_s;
                end
                LC_TWO: begin
                    t1_s = l1_q_s;
                    t2_s = l2_q_s;
                end
                default: begin
                    t1_s = s1_x_r;
                    t2_s = s1_x_r;
                end
            endcase
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum_s = {2'b00, t2_s[ch*DATA_W +: DATA_W]}
                  + {1'b0, t1_s[ch*DATA_W +: DATA_W], 1'b0}
                  + {2'b00, s1_x_r[ch*DATA_W +: DATA_W]}
                  + SUM_RND;
            f_s[ch*DATA_W +: DATA_W] = DATA_W'(sum_s >> 2);
        end
    end

    // Stage 2 register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            s2_vs_r <= 1'b0;
            s2_hs_r <= 1'b0;
            s2_de_r <= 1'b0;
            s2_x_r  <= '0;
            s2_f_r  <= '0;
        end else begin
            s2_vs_r <= s1_vs_r;
            s2_hs_r <= s1_hs_r;
            s2_de_r <= s1_de_r;
            s2_x_r  <= s1_x_r;
            s2_f_r  <= f_s;
        end
    end

    // Stage 3 datapath: saturating offset, or raw input when bypassed.
    always_comb begin
        y_s   = '0;
        add_s = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            add_s = {1'b0, s2_f_r[ch*DATA_W +: DATA_W]} + {1'b0, off_r};
            if (byp_r) begin
                y_s[ch*DATA_W +: DATA_W] = s2_x_r[ch*DATA_W +: DATA_W];
            end else if (add_s[DATA_W]) begin
                y_s[ch*DATA_W +: DATA_W] = '1;
            end else begin
                y_s[ch*DATA_W +: DATA_W] = add_s[DATA_W-1:0];
            end
        end
    end

    // Stage 3: output register, data blanked outside DE.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_vsync <= 1'b0;
            o_hsync <= 1'b0;
            o_de    <= 1'b0;
            o_data  <= '0;
        end else begin
            o_vsync <= s2_vs_r;
            o_hsync <= s2_hs_r;
            o_de    <= s2_de_r;
            o_data  <= s2_de_r ? y_s : '0;
        end
    end

endmodule
